// File: rtl/display_scan_mux.sv
// Debug-display channel selector with manual, timed auto-scan and push-button step modes.
// Optional snapshot/freeze support is built when DISPLAY_FREEZE_EN is defined.
module display_scan_mux #(
  parameter int unsigned CH_COUNT  = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned SEL_W     = 4,
  parameter int unsigned DWELL     = 50_000_000,
  parameter logic [31:0] BLANK_VAL = 32'h0000F0F0
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         en_n,
  input  logic [1:0]                   mode,
  input  logic [SEL_W-1:0]             sel,
  input  logic                         step,
  input  logic                         freeze,
  input  logic [CH_COUNT*DATA_W-1:0]   ch_data,
  output logic [DATA_W-1:0]            hex_display,
  output logic [SEL_W-1:0]             cur_ch,
  output logic                         disp_valid
);

  localparam int unsigned       CNT_W    = $clog2(DWELL);
  localparam logic [DATA_W-1:0] BLANK    = DATA_W'(BLANK_VAL);
  localparam logic [SEL_W-1:0]  LAST_CH  = SEL_W'(CH_COUNT - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {OFF = 2'd0, MANUAL = 2'd1, SCAN = 2'd2, STEP = 2'd3} state_t;

  state_t                     state;
  state_t                     req_state;
  logic [CNT_W-1:0]           dwell_cnt;
  logic                       step_q;
  logic                       entering;
  logic                       advance;
  logic [SEL_W-1:0]           idx_next;
  logic [CH_COUNT*DATA_W-1:0] src;
  logic [DATA_W-1:0]          src_word;
  logic                       idx_ok;

`ifdef DISPLAY_FREEZE_EN
  logic                       freeze_q;
  logic [CH_COUNT*DATA_W-1:0] snap;

  // Snapshot taken on an enabled rising edge of freeze; shown while freeze stays high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      freeze_q <= 1'b0;
      snap     <= '0;
    end else if (!en_n) begin
      freeze_q <= freeze;
      if (freeze && !freeze_q) snap <= ch_data;
    end
  end

  assign src = (freeze && freeze_q) ? snap : ch_data;
`else
  logic unused_freeze;
  assign unused_freeze = freeze;
  assign src = ch_data;
`endif

  // Requested state, channel index for this edge and the word it selects.
  always_comb begin
    req_state = OFF;
    case (mode)
      2'b00:   req_state = MANUAL;
      2'b01:   req_state = SCAN;
      2'b10:   req_state = STEP;
      default: req_state = OFF;
    endcase

    entering = (req_state == SCAN || req_state == STEP) && (state != req_state);
    advance  = 1'b0;
    if (!entering) begin
      if (req_state == SCAN)      advance = (dwell_cnt == LAST_CNT);
      else if (req_state == STEP) advance = step & ~step_q;
    end

    idx_next = cur_ch;
    if (req_state == MANUAL) begin
      idx_next = sel;
    end else if (entering) begin
      if (cur_ch > LAST_CH) idx_next = '0;
    end else if (advance) begin
      idx_next = (cur_ch == LAST_CH) ? '0 : cur_ch + SEL_W'(1);
    end

    src_word = BLANK;
    idx_ok   = 1'b0;
    for (int unsigned k = 0; k < CH_COUNT; k++) begin
      if (idx_next == SEL_W'(k)) begin
        src_word = src[k*DATA_W +: DATA_W];
        idx_ok   = 1'b1;
      end
    end
  end

  // Disabled display blanks and freezes everything except the step edge detector.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= OFF;
      hex_display <= BLANK;
      cur_ch      <= '0;
      disp_valid  <= 1'b0;
      dwell_cnt   <= '0;
      step_q      <= 1'b0;
    end else begin
      step_q <= step;
      if (en_n) begin
        hex_display <= BLANK;
        disp_valid  <= 1'b0;
      end else begin
        state  <= req_state;
        cur_ch <= idx_next;
        if (req_state == SCAN && !entering)
          dwell_cnt <= advance ? '0 : dwell_cnt + CNT_W'(1);
        else if (entering || state == SCAN)
          dwell_cnt <= '0;
        if (req_state == OFF) begin
          hex_display <= BLANK;
          disp_valid  <= 1'b0;
        end else begin
          hex_display <= src_word;
          disp_valid  <= idx_ok;
        end
      end
    end
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux with CH_COUNT=8, DATA_W=32, DWELL=4.
// Expected freeze behaviour follows DISPLAY_FREEZE_EN as defined for the build.
module tb_display_scan_mux;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         en_n;
  logic [1:0]   mode;
  logic [3:0]   sel;
  logic         step;
  logic         freeze;
  logic [255:0] ch_data;
  logic [31:0]  hex_display;
  logic [3:0]   cur_ch;
  logic         disp_valid;
  logic [31:0]  ch [8];

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] BLANK = 32'h0000F0F0;

  display_scan_mux #(
    .CH_COUNT(8), .DATA_W(32), .SEL_W(4), .DWELL(4), .BLANK_VAL(32'h0000F0F0)
  ) dut (
    .clock(clock), .reset_n(reset_n), .en_n(en_n), .mode(mode), .sel(sel),
    .step(step), .freeze(freeze), .ch_data(ch_data),
    .hex_display(hex_display), .cur_ch(cur_ch), .disp_valid(disp_valid)
  );

  always #5 clock = ~clock;

  always_comb begin
    for (int k = 0; k < 8; k++) ch_data[k*32 +: 32] = ch[k];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1; mode = 2'b00; sel = 4'd5;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    checks++; if (hex_display !== BLANK) begin errors++; $display("FAIL reset_hex: got %h expected %h", hex_display, BLANK); end
    checks++; if (cur_ch !== 4'd0) begin errors++; $display("FAIL reset_cur: got %0d expected 0", cur_ch); end
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", disp_valid); end
    #2;
    reset_n = 1'b1; sel = 4'd3;
    tick();
    checks++; if (hex_display !== 32'h1000_0003) begin errors++; $display("FAIL manual3_hex: got %h expected 10000003", hex_display); end
    checks++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL manual3_valid: got %b expected 1", disp_valid); end
    checks++; if (cur_ch !== 4'd3) begin errors++; $display("FAIL manual3_cur: got %0d expected 3", cur_ch); end
  endtask

  task automatic test_manual_oob();
    mode = 2'b00; sel = 4'd9;
    tick();
    checks++; if (hex_display !== BLANK) begin errors++; $display("FAIL oob_hex: got %h expected %h", hex_display, BLANK); end
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL oob_valid: got %b expected 0", disp_valid); end
    checks++; if (cur_ch !== 4'd9) begin errors++; $display("FAIL oob_cur: got %0d expected 9", cur_ch); end
    mode = 2'b01;
    tick();
    checks++; if (cur_ch !== 4'd0) begin errors++; $display("FAIL oob_scan_cur: got %0d expected 0", cur_ch); end
    checks++; if (hex_display !== 32'h1000_0000) begin errors++; $display("FAIL oob_scan_hex: got %h expected 10000000", hex_display); end
  endtask

  task automatic test_scan();
    logic [3:0]  exp_ch [12] = '{4'd6, 4'd6, 4'd6, 4'd6, 4'd7, 4'd7, 4'd7, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0};
    logic [31:0] exp_hex [12] = '{32'h1000_0006, 32'h1000_0006, 32'h1000_0006, 32'h1000_0006,
                                  32'h1000_0007, 32'h7777_0007, 32'h7777_0007, 32'h7777_0007,
                                  32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000};
    mode = 2'b00; sel = 4'd6;
    tick();
    mode = 2'b01;
    for (int i = 0; i < 12; i++) begin
      if (i == 5) ch[7] = 32'h7777_0007;
      tick();
      checks++; if (cur_ch !== exp_ch[i]) begin errors++; $display("FAIL scan_cur[%0d]: got %0d expected %0d", i, cur_ch, exp_ch[i]); end
      checks++; if (hex_display !== exp_hex[i]) begin errors++; $display("FAIL scan_hex[%0d]: got %h expected %h", i, hex_display, exp_hex[i]); end
    end
    ch[7] = 32'h1000_0007;
  endtask

  task automatic test_step();
    logic [3:0] pulse_exp [3] = '{4'd0, 4'd1, 4'd2};
    mode = 2'b00; sel = 4'd2; step = 1'b0;
    tick();
    mode = 2'b10;
    tick();
    checks++; if (cur_ch !== 4'd2) begin errors++; $display("FAIL step_entry_cur: got %0d expected 2", cur_ch); end
    step = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (cur_ch !== 4'd3) begin errors++; $display("FAIL step_hold_cur[%0d]: got %0d expected 3", i, cur_ch); end
    end
    checks++; if (hex_display !== 32'h1000_0003) begin errors++; $display("FAIL step_hold_hex: got %h expected 10000003", hex_display); end
    step = 1'b0; mode = 2'b00; sel = 4'd7;
    tick();
    mode = 2'b10;
    tick();
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      tick();
      checks++; if (cur_ch !== pulse_exp[i]) begin errors++; $display("FAIL step_pulse_cur[%0d]: got %0d expected %0d", i, cur_ch, pulse_exp[i]); end
      step = 1'b0;
      tick();
    end
    checks++; if (hex_display !== 32'h1000_0002) begin errors++; $display("FAIL step_pulse_hex: got %h expected 10000002", hex_display); end
  endtask

  task automatic test_enable();
    mode = 2'b00; sel = 4'd5;
    tick();
    mode = 2'b01;
    tick();
    tick();
    tick();
    en_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (hex_display !== BLANK) begin errors++; $display("FAIL en_hex[%0d]: got %h expected %h", i, hex_display, BLANK); end
      checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL en_valid[%0d]: got %b expected 0", i, disp_valid); end
      checks++; if (cur_ch !== 4'd5) begin errors++; $display("FAIL en_cur[%0d]: got %0d expected 5", i, cur_ch); end
    end
    en_n = 1'b0;
    tick();
    checks++; if (cur_ch !== 4'd5) begin errors++; $display("FAIL en_resume_cur0: got %0d expected 5", cur_ch); end
    checks++; if (hex_display !== 32'h1000_0005) begin errors++; $display("FAIL en_resume_hex: got %h expected 10000005", hex_display); end
    tick();
    checks++; if (cur_ch !== 4'd6) begin errors++; $display("FAIL en_resume_cur1: got %0d expected 6", cur_ch); end
    mode = 2'b11;
    tick();
    checks++; if (hex_display !== BLANK) begin errors++; $display("FAIL blank_hex: got %h expected %h", hex_display, BLANK); end
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL blank_valid: got %b expected 0", disp_valid); end
    checks++; if (cur_ch !== 4'd6) begin errors++; $display("FAIL blank_cur: got %0d expected 6", cur_ch); end
  endtask

  task automatic test_reset_mid_scan();
    mode = 2'b00; sel = 4'd3;
    tick();
    mode = 2'b01;
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    tick();
    checks++; if (cur_ch !== 4'd0) begin errors++; $display("FAIL rst_scan_cur: got %0d expected 0", cur_ch); end
    checks++; if (hex_display !== 32'h1000_0000) begin errors++; $display("FAIL rst_scan_hex: got %h expected 10000000", hex_display); end
    checks++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL rst_scan_valid: got %b expected 1", disp_valid); end
  endtask

  task automatic test_freeze();
    logic [31:0] exp_frozen;
`ifdef DISPLAY_FREEZE_EN
    exp_frozen = 32'h1000_0002;
`else
    exp_frozen = 32'hDEAD_BEEF;
`endif
    mode = 2'b00; sel = 4'd0; step = 1'b0; freeze = 1'b0;
    tick();
    mode = 2'b10;
    tick();
    freeze = 1'b1;
    tick();
    ch[2] = 32'hDEAD_BEEF;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    step = 1'b1;
    tick();
    checks++; if (cur_ch !== 4'd2) begin errors++; $display("FAIL frz_cur: got %0d expected 2", cur_ch); end
    checks++; if (hex_display !== exp_frozen) begin errors++; $display("FAIL frz_hex: got %h expected %h", hex_display, exp_frozen); end
    step = 1'b0; freeze = 1'b0;
    tick();
    checks++; if (hex_display !== 32'hDEAD_BEEF) begin errors++; $display("FAIL unfrz_hex: got %h expected deadbeef", hex_display); end
    checks++; if (cur_ch !== 4'd2) begin errors++; $display("FAIL unfrz_cur: got %0d expected 2", cur_ch); end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) ch[k] = 32'h1000_0000 + 32'(k);
    reset_n = 1'b0; en_n = 1'b0; mode = 2'b00; sel = 4'd0;
    step = 1'b0; freeze = 1'b0;
    #12;
    test_reset();
    test_manual_oob();
    test_scan();
    test_step();
    test_enable();
    test_reset_mid_scan();
    test_freeze();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
